rom_port_arbiter: RTL and testbench



---
 rtl/rom_arb_pkg.sv | 19 +
 rtl/rom_port_arbiter_if.sv | 42 ++++
 rtl/rom_arb_grant.sv | 38 +++
 rtl/rom_port_arbiter.sv | 113 +++++++++++
 tb/tb_rom_port_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// Shared encodings and defaults for the ROM port arbiter.
package rom_arb_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Requester request/response channels plus the ROM read port.
interface rom_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12
);
  logic                            if_req_valid;
  logic                            if_req_ready;
  logic [rom_arb_pkg::DATA_W-1:0]  if_addr;
  logic                            if_rsp_valid;
  logic                            if_rsp_ready;
  logic [rom_arb_pkg::DATA_W-1:0]  if_rsp_data;
  logic                            if_rsp_err;

  logic                            d_req_valid;
  logic                            d_req_ready;
  logic [rom_arb_pkg::DATA_W-1:0]  d_addr;
  logic                            d_rsp_valid;
  logic                            d_rsp_ready;
  logic [rom_arb_pkg::DATA_W-1:0]  d_rsp_data;
  logic                            d_rsp_err;

  logic                            rom_en;
  logic [ADDR_W-1:0]               rom_addr;
  logic [rom_arb_pkg::DATA_W-1:0]  rom_rdata;

  modport slave (
    input  if_req_valid, if_addr, if_rsp_ready,
    input  d_req_valid, d_addr, d_rsp_ready,
    input  rom_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output rom_en, rom_addr
  );

  modport master (
    output if_req_valid, if_addr, if_rsp_ready,
    output d_req_valid, d_addr, d_rsp_ready,
    output rom_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  rom_en, rom_addr
  );
endinterface

// File: rtl/rom_arb_grant.sv
// Data-over-fetch priority select with a saturating fetch starvation counter.
module rom_arb_grant
  import rom_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_if_valid,
  input  logic             i_d_valid,
  input  logic             i_accept,
  output logic             o_grant_if,
  output logic             o_grant_d,
  output logic [CNT_W-1:0] o_starve_cnt
);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved    = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign o_grant_if   = i_if_valid & (~i_d_valid | w_starved);
  assign o_grant_d    = i_d_valid & ~o_grant_if;
  assign o_starve_cnt = r_starve_cnt;

  // Counts data wins over a waiting fetch; any fetch accept clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (i_accept) begin
      if (o_grant_if) begin
        r_starve_cnt <= '0;
      end else if (o_grant_d && i_if_valid && (r_starve_cnt < CNT_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one synchronous-read ROM between fetch and load requesters.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned WORDS        = 4096,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  rom_port_arbiter_if.slave  bus
);

  state_e              r_state;
  state_e              w_next_state;
  owner_e              r_owner;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;

  logic                w_idle;
  logic                w_grant_if;
  logic                w_grant_d;
  logic                w_accept;
  logic                w_addr_err;
  logic                w_rsp_ready;
  logic [DATA_W-1:0]   w_addr;
  logic [CNT_W-1:0]    w_starve_cnt;

  rom_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_if_valid   (bus.if_req_valid),
    .i_d_valid    (bus.d_req_valid),
    .i_accept     (w_accept),
    .o_grant_if   (w_grant_if),
    .o_grant_d    (w_grant_d),
    .o_starve_cnt (w_starve_cnt)
  );

  // Ready is suppressed while reset is held so outputs show reset values.
  assign w_idle      = (r_state == IDLE) & rst_n;
  assign w_accept    = w_idle & (w_grant_if | w_grant_d);
  assign w_addr      = w_grant_d ? bus.d_addr : bus.if_addr;
  assign w_addr_err  = (w_addr[1:0] != 2'b00) || (w_addr[DATA_W-1:2] >= (DATA_W-2)'(WORDS));
  assign w_rsp_ready = (r_owner == OWN_D) ? bus.d_rsp_ready : bus.if_rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = w_addr_err ? RESP : WAIT;
      WAIT:    w_next_state = RESP;
      RESP:    if (w_rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.if_req_ready = 1'b0;
    bus.d_req_ready  = 1'b0;
    bus.rom_en       = 1'b0;
    bus.rom_addr     = '0;
    bus.if_rsp_valid = 1'b0;
    bus.d_rsp_valid  = 1'b0;
    if (w_idle) begin
      bus.if_req_ready = w_grant_if;
      bus.d_req_ready  = w_grant_d;
      if (w_accept && !w_addr_err) begin
        bus.rom_en   = 1'b1;
        bus.rom_addr = w_addr[ADDR_W+1:2];
      end
    end
    if (r_state == RESP) begin
      bus.if_rsp_valid = (r_owner == OWN_IF);
      bus.d_rsp_valid  = (r_owner == OWN_D);
    end
  end

  // Owner and response word: error responses are formed at accept, ROM data in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= OWN_IF;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_owner    <= w_grant_d ? OWN_D : OWN_IF;
      r_rsp_data <= '0;
      r_rsp_err  <= w_addr_err;
    end else if (r_state == WAIT) begin
      r_rsp_data <= bus.rom_rdata;
      r_rsp_err  <= 1'b0;
    end
  end

  assign bus.if_rsp_data = r_rsp_data;
  assign bus.if_rsp_err  = r_rsp_err;
  assign bus.d_rsp_data  = r_rsp_data;
  assign bus.d_rsp_err   = r_rsp_err;

  always_ff @(posedge clk) begin
    if (rst_n) assert (w_starve_cnt <= CNT_W'(STARVE_LIMIT));
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with an expected-response scoreboard.
module tb_rom_port_arbiter;
  import rom_arb_pkg::*;

  localparam int unsigned WORDS  = 4096;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LIMIT  = 4;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  rom_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  rom_port_arbiter #(
    .WORDS        (WORDS),
    .ADDR_W       (ADDR_W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rom_mem [WORDS];
  always @(posedge clk) if (bus.rom_en) bus.rom_rdata <= rom_mem[bus.rom_addr];

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_4000);
  endfunction

  // Polls ready from now until a grant appears; reports cycles waited.
  task automatic wait_grant(input string tag, output int cycles);
    bit ok = 0;
    cycles = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.if_req_ready || bus.d_req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_grant_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic accept_chk(input bit is_d, input logic [31:0] a, input string tag);
    exp_t e;
    logic err;
    err = bad_addr(a);
    chk({tag, "_owner_d"},  32'(bus.d_req_ready),  32'(is_d));
    chk({tag, "_owner_if"}, 32'(bus.if_req_ready), 32'(!is_d));
    chk({tag, "_rom_en"},   32'(bus.rom_en),       32'(!err));
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr),     err ? 32'd0 : 32'(a[13:2]));
    e.is_d = is_d;
    e.err  = err;
    e.data = err ? 32'd0 : rom_mem[a[13:2]];
    sb.push_back(e);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int   k = 0;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(e.is_d ? bus.d_rsp_valid : bus.if_rsp_valid) && k < 10);
    chk({tag, "_latency"},     32'(k), e.err ? 32'd1 : 32'd2);
    chk({tag, "_data"},        e.is_d ? bus.d_rsp_data : bus.if_rsp_data, e.data);
    chk({tag, "_err"},         32'(e.is_d ? bus.d_rsp_err : bus.if_rsp_err), 32'(e.err));
    chk({tag, "_other_valid"}, 32'(e.is_d ? bus.if_rsp_valid : bus.d_rsp_valid), 32'd0);
    chk({tag, "_rom_idle"},    32'(bus.rom_en), 32'd0);
    last_data = e.data;
  endtask

  task automatic serve(input bit is_d, input logic [31:0] a, input string tag);
    int cyc;
    @(negedge clk);
    if (is_d) begin bus.d_req_valid = 1'b1; bus.d_addr = a; end
    else      begin bus.if_req_valid = 1'b1; bus.if_addr = a; end
    wait_grant(tag, cyc);
    accept_chk(is_d, a, tag);
    @(posedge clk);
    #1;
    bus.d_req_valid  = 1'b0;
    bus.if_req_valid = 1'b0;
    collect(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_ready"}, 32'(bus.if_req_ready), 32'd0);
    chk({tag, "_d_ready"},  32'(bus.d_req_ready),  32'd0);
    chk({tag, "_if_valid"}, 32'(bus.if_rsp_valid), 32'd0);
    chk({tag, "_d_valid"},  32'(bus.d_rsp_valid),  32'd0);
    chk({tag, "_if_data"},  bus.if_rsp_data,       32'd0);
    chk({tag, "_d_data"},   bus.d_rsp_data,        32'd0);
    chk({tag, "_if_err"},   32'(bus.if_rsp_err),   32'd0);
    chk({tag, "_d_err"},    32'(bus.d_rsp_err),    32'd0);
    chk({tag, "_rom_en"},   32'(bus.rom_en),       32'd0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_addr),     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] ia, da;
    bit          exp_d;

    for (int i = 0; i < int'(WORDS); i++) rom_mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
    rom_mem[2]    = 32'hDEAD_BEEF;
    rom_mem[4095] = 32'hFEED_0FFF;

    bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.if_rsp_ready = 1'b1;
    bus.d_req_valid  = 1'b0; bus.d_addr  = '0; bus.d_rsp_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single accesses, errors and the last word
    serve(1'b0, 32'h0000_0008, "fetch_w2");
    serve(1'b1, 32'h0000_0006, "d_misalign");
    serve(1'b1, 32'h0000_0100, "d_load");
    serve(1'b0, 32'h0000_4000, "if_range");
    serve(1'b0, 32'h0000_3FFC, "if_last");

    // Contention with both requesters always valid
    @(negedge clk);
    ia = 32'h0000_0040;
    da = 32'h0000_0200;
    bus.if_addr = ia; bus.d_addr = da;
    bus.if_req_valid = 1'b1; bus.d_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_d = ((i % 5) != 4);
      wait_grant("contend", cyc);
      accept_chk(exp_d, exp_d ? da : ia, "contend");
      collect("contend");
      if (exp_d) begin da = da + 32'd4; bus.d_addr = da; end
      else       begin ia = ia + 32'd4; bus.if_addr = ia; end
    end
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;

    // Back-pressure on the load response
    @(negedge clk);
    bus.d_rsp_ready = 1'b0;
    bus.d_addr = 32'h0000_0300;
    bus.d_req_valid = 1'b1;
    wait_grant("bp", cyc);
    accept_chk(1'b1, 32'h0000_0300, "bp");
    @(posedge clk);
    #1;
    bus.d_req_valid = 1'b0;
    collect("bp");
    bus.if_addr = 32'h0000_0044;
    bus.if_req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid",    32'(bus.d_rsp_valid),  32'd1);
      chk("bp_hold_data",     bus.d_rsp_data,        last_data);
      chk("bp_hold_err",      32'(bus.d_rsp_err),    32'd0);
      chk("bp_hold_if_ready", 32'(bus.if_req_ready), 32'd0);
      chk("bp_hold_rom_en",   32'(bus.rom_en),       32'd0);
    end
    bus.d_rsp_ready = 1'b1;
    #1;
    chk("bp_release_if_ready", 32'(bus.if_req_ready), 32'd0);
    wait_grant("bp_next", cyc);
    chk("bp_next_gap", 32'(cyc), 32'd1);
    accept_chk(1'b0, 32'h0000_0044, "bp_next");
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b0;
    collect("bp_next");

    // Reset while the fetch is waiting on ROM data
    @(negedge clk);
    bus.if_addr = 32'h0000_0010;
    bus.if_req_valid = 1'b1;
    wait_grant("rst", cyc);
    accept_chk(1'b0, 32'h0000_0010, "rst");
    @(posedge clk);
    #1;
    bus.if_req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid_wait");
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("rst_no_if_rsp", 32'(bus.if_rsp_valid), 32'd0);
      chk("rst_no_d_rsp",  32'(bus.d_rsp_valid),  32'd0);
    end
    serve(1'b0, 32'h0000_0008, "post_rst");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
